uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 53 +++++
 rtl/uart_link.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_link.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared UART definitions: default bit timing and one-hot RX/TX state encodings.
package uart_link_pkg;

  // 12 MHz system clock, 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RX_STATE_W = 5;
  localparam int unsigned TX_STATE_W = 4;

  typedef enum logic [RX_STATE_W-1:0] {
    RX_IDLE  = 5'b00001,
    RX_START = 5'b00010,
    RX_DATA  = 5'b00100,
    RX_STOP  = 5'b01000,
    RX_BREAK = 5'b10000
  } rx_state_t;

  typedef enum logic [TX_STATE_W-1:0] {
    TX_IDLE  = 4'b0001,
    TX_START = 4'b0010,
    TX_DATA  = 4'b0100,
    TX_STOP  = 4'b1000
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-visible byte FIFO: head entry is read straight from storage.
module byte_fifo
  import uart_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = BYTE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_link.sv
// 8N1 UART link: synchronized receiver feeding a byte FIFO, plus an independent transmitter.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_rx_i,
  output logic              uart_tx_o,
  output logic [BYTE_W-1:0] read_data_o,
  output logic              read_valid_o,
  input  logic              read_ready_i,
  input  logic [BYTE_W-1:0] write_data_i,
  input  logic              write_valid_i,
  output logic              write_ready_o,
  output logic              error_overflow_o,
  output logic              error_framing_o,
  input  logic              error_clear_i
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_W - 1);

  // ---------------- receive path ----------------
  logic [1:0]        rx_sync;
  logic              rx_bit;
  rx_state_t         rx_state, rx_state_next;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_next;
  logic [IDX_W-1:0]  rx_idx, rx_idx_next;
  logic [BYTE_W-1:0] rx_shift, rx_shift_next;
  logic              rx_tick;
  logic              rx_push_c;
  logic              rx_frame_err_c;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              overflow_c;

  // Two-flop synchronizer; resets to idle-high so reset release never fakes a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], uart_rx_i};
  end

  assign rx_bit  = rx_sync[1];
  assign rx_tick = (rx_cnt == '0);

  // RX state register and bit-timing datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_idx   <= rx_idx_next;
      rx_shift <= rx_shift_next;
    end
  end

  // RX next state: half-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_idx_next   = rx_idx;
    rx_shift_next = rx_shift;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_bit) begin
          rx_state_next = RX_START;
          rx_cnt_next   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_bit) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = BIT_LAST;
            rx_idx_next   = '0;
          end
        end else begin
          rx_cnt_next = rx_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_next = {rx_bit, rx_shift[BYTE_W-1:1]};
          rx_cnt_next   = BIT_LAST;
          if (rx_idx == IDX_LAST) rx_state_next = RX_STOP;
          else                    rx_idx_next   = rx_idx + IDX_W'(1);
        end else begin
          rx_cnt_next = rx_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_tick) rx_state_next = rx_bit ? RX_IDLE : RX_BREAK;
        else         rx_cnt_next   = rx_cnt - CNT_W'(1);
      end
      RX_BREAK: begin
        if (rx_bit) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // RX outputs: push or framing error on the stop-sample cycle.
  always_comb begin
    rx_push_c      = 1'b0;
    rx_frame_err_c = 1'b0;
    if ((rx_state == RX_STOP) && rx_tick) begin
      rx_push_c      = rx_bit;
      rx_frame_err_c = ~rx_bit;
    end
  end

  assign fifo_pop     = read_valid_o & read_ready_i;
  assign read_valid_o = ~fifo_empty;
  assign overflow_c   = rx_push_c & fifo_full & ~fifo_pop;

  byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (BYTE_W)
  ) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push_c),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (read_data_o)
  );

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_overflow_o <= 1'b0;
      error_framing_o  <= 1'b0;
    end else begin
      error_overflow_o <= overflow_c     | (error_overflow_o & ~error_clear_i);
      error_framing_o  <= rx_frame_err_c | (error_framing_o  & ~error_clear_i);
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t         tx_state, tx_state_next;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_next;
  logic [IDX_W-1:0]  tx_idx, tx_idx_next;
  logic [BYTE_W-1:0] tx_shift, tx_shift_next;
  logic              tx_tick;
  logic              tx_line_c;

  assign tx_tick = (tx_cnt == '0);

  // TX state register plus registered line and ready outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_idx        <= '0;
      tx_shift      <= '0;
      uart_tx_o     <= 1'b1;
      write_ready_o <= 1'b1;
    end else begin
      tx_state      <= tx_state_next;
      tx_cnt        <= tx_cnt_next;
      tx_idx        <= tx_idx_next;
      tx_shift      <= tx_shift_next;
      uart_tx_o     <= tx_line_c;
      write_ready_o <= (tx_state_next == TX_IDLE);
    end
  end

  // TX next state: latch on acceptance, then start, 8 data and stop bits.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        if (write_valid_i) begin
          tx_state_next = TX_START;
          tx_cnt_next   = BIT_LAST;
          tx_idx_next   = '0;
          tx_shift_next = write_data_i;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = BIT_LAST;
        end else begin
          tx_cnt_next = tx_cnt - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_next = BIT_LAST;
          if (tx_idx == IDX_LAST) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_idx_next   = tx_idx + IDX_W'(1);
            tx_shift_next = {1'b0, tx_shift[BYTE_W-1:1]};
          end
        end else begin
          tx_cnt_next = tx_cnt - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_tick) tx_state_next = TX_IDLE;
        else         tx_cnt_next   = tx_cnt - CNT_W'(1);
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // TX line level for the upcoming cycle, derived from the next state.
  always_comb begin
    tx_line_c = 1'b1;
    case (tx_state_next)
      TX_START: tx_line_c = 1'b0;
      TX_DATA:  tx_line_c = tx_shift_next[0];
      default:  tx_line_c = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_link.sv
// Scoreboard bench for uart_link: random full-duplex traffic plus directed corner cases.
module tb_uart_link;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_drive;
  logic       loopback;
  logic       rx_line;
  logic       uart_tx;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_ready = 1'b0;
  logic [7:0] write_data;
  logic       write_valid;
  logic       write_ready;
  logic       err_ovf;
  logic       err_frm;
  logic       err_clear;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic       exp_ovf;
  logic       exp_frm;
  int         ready_mode = 1;

  always #5 clock = ~clock;

  assign rx_line = loopback ? uart_tx : rx_drive;

  uart_link #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx_i        (rx_line),
    .uart_tx_o        (uart_tx),
    .read_data_o      (read_data),
    .read_valid_o     (read_valid),
    .read_ready_i     (read_ready),
    .write_data_i     (write_data),
    .write_valid_i    (write_valid),
    .write_ready_o    (write_ready),
    .error_overflow_o (err_ovf),
    .error_framing_o  (err_frm),
    .error_clear_i    (err_clear)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check1({tag, "_ovf"}, err_ovf, exp_ovf);
    check1({tag, "_frm"}, err_frm, exp_frm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Consumer ready: held low, held high, or random per cycle.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       read_ready = 1'b0;
      1:       read_ready = 1'b1;
      default: read_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // RX monitor: every FIFO handshake must match the oldest expected byte.
  always @(negedge clock) begin
    if (!reset && read_valid && read_ready) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %h want nothing at %0t", read_data, $time);
      end else begin
        check8("rx_data", read_data, exp_rx.pop_front());
      end
    end
  end

  // TX monitor: decode frames off the line by mid-bit sampling.
  bit        mon_active = 1'b0;
  int        mon_t = 0;
  logic [9:0] mon_frame = '0;
  always @(negedge clock) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
      end
    end else begin
      mon_t++;
      if ((mon_t % CPB) == (CPB / 2)) mon_frame = {uart_tx, mon_frame[9:1]};
      if (mon_t == 9 * CPB + CPB / 2) begin
        mon_active = 1'b0;
        check1("tx_start_bit", mon_frame[0], 1'b0);
        check1("tx_stop_bit", mon_frame[9], 1'b1);
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %h want nothing at %0t", mon_frame[8:1], $time);
        end else begin
          check8("tx_byte", mon_frame[8:1], exp_tx.pop_front());
        end
      end
    end
  end

  // Model of the receive side: a good byte is kept only if the FIFO has room.
  task automatic model_rx(input logic [7:0] b);
    if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
    else                       exp_ovf = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    if (stop_ok) model_rx(b);
    else         exp_frm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_drive = fr[0];
      fr = fr >> 1;
      tick(CPB);
    end
    rx_drive = 1'b1;
  endtask

  // Offer a byte; returns one cycle after the accepting edge.
  task automatic send_tx(input logic [7:0] b, input logic expect_it, input logic looped);
    int guard;
    guard = 0;
    while (write_ready !== 1'b1 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL tx_ready_timeout: got %b want 1", write_ready);
    end
    write_data  = b;
    write_valid = 1'b1;
    if (expect_it) exp_tx.push_back(b);
    if (looped)    model_rx(b);
    tick(1);
    write_valid = 1'b0;
    write_data  = 8'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && n < 400) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_drain: rx_left=%0d tx_left=%0d want 0", name, exp_rx.size(), exp_tx.size());
    end
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    exp_ovf   = 1'b0;
    exp_frm   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] ra, rb;
    reset       = 1'b1;
    rx_drive    = 1'b1;
    loopback    = 1'b0;
    write_valid = 1'b0;
    write_data  = 8'h00;
    err_clear   = 1'b0;
    exp_ovf     = 1'b0;
    exp_frm     = 1'b0;
    tick(3);
    check1("rst_tx_line", uart_tx, 1'b1);
    check1("rst_read_valid", read_valid, 1'b0);
    reset = 1'b0;
    tick(2);
    check1("rst_write_ready", write_ready, 1'b1);
    check_flags("rst");

    // Single received byte, consumed immediately.
    ready_mode = 0;
    send_rx(8'hA5, 1'b1);
    tick(2);
    check1("a5_valid", read_valid, 1'b1);
    check8("a5_head", read_data, 8'hA5);
    ready_mode = 1;
    wait_drain("a5");
    tick(2);
    check1("a5_popped", read_valid, 1'b0);
    check_flags("a5");

    // Cycle-exact transmit waveform; data input scrambled after acceptance.
    send_tx(8'h3C, 1'b1, 1'b0);
    fr = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        check1("tx_wave", uart_tx, fr[0]);
        check1("tx_busy", write_ready, 1'b0);
        tick(1);
      end
      fr = fr >> 1;
    end
    check1("tx_ready_back", write_ready, 1'b1);
    check1("tx_idle_line", uart_tx, 1'b1);
    wait_drain("3c");

    // Overflow: six bytes into a four-entry FIFO with no consumer.
    ready_mode = 0;
    tick(2);
    for (int b = 1; b <= 6; b++) send_rx(8'(b), 1'b1);
    tick(4);
    check1("ovf_valid", read_valid, 1'b1);
    check8("ovf_head", read_data, 8'h01);
    check_flags("ovf");
    ready_mode = 1;
    wait_drain("ovf");
    tick(2);
    check1("ovf_empty", read_valid, 1'b0);
    pulse_clear();
    check_flags("ovf_clr");

    // Framing error, recovery frame, then clear.
    send_rx(8'h55, 1'b0);
    tick(6);
    check1("frm_no_push", read_valid, 1'b0);
    check_flags("frm");
    send_rx(8'h77, 1'b1);
    wait_drain("frm");
    check_flags("frm_after");
    pulse_clear();
    check_flags("frm_clr");

    // Short low glitch on the line.
    rx_drive = 1'b0;
    tick(2);
    rx_drive = 1'b1;
    tick(12);
    check1("glitch_no_push", read_valid, 1'b0);
    check_flags("glitch");

    // Random full-duplex traffic with a randomly stalling consumer.
    ready_mode = 2;
    repeat (12) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      fork
        send_rx(ra, 1'b1);
        send_tx(rb, 1'b1, 1'b0);
      join
    end
    ready_mode = 1;
    wait_drain("random");
    check_flags("random");

    // Reset mid-frame on both directions with a byte parked in the FIFO.
    ready_mode = 0;
    tick(2);
    send_rx(8'h3A, 1'b1);
    tick(2);
    check1("prereset_valid", read_valid, 1'b1);
    send_tx(8'hF0, 1'b0, 1'b0);
    rx_drive = 1'b0;
    tick(17);
    reset = 1'b1;
    #1;
    check1("midrst_tx_line", uart_tx, 1'b1);
    check1("midrst_valid", read_valid, 1'b0);
    exp_rx.delete();
    exp_tx.delete();
    exp_ovf  = 1'b0;
    exp_frm  = 1'b0;
    rx_drive = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check1("postrst_ready", write_ready, 1'b1);
    check1("postrst_valid", read_valid, 1'b0);
    check_flags("postrst");
    ready_mode = 1;

    // Loopback round trip after reset.
    loopback = 1'b1;
    tick(2);
    send_tx(8'h81, 1'b1, 1'b1);
    wait_drain("loop");
    tick(4);
    check1("loop_empty", read_valid, 1'b0);
    check_flags("loop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
